// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: bit-serial configuration loader and output stage for a
// single 2-input LUT CLB. A frame is shifted in LSB first (lut[3:0], use_ff,
// ff_init and, with parity enabled, an even-parity bit), checked, and then
// committed to the active configuration that drives the LUT and its output flop.
//
// Optional feature macro: CLB_CFG_PARITY_EN
//   defined   -> 7-bit frame with even parity over all bits; bad frames set cfg_err
//   undefined -> 6-bit frame, every frame commits, cfg_err stays 0
//
// Pad handshake: a bit is transferred on every rising edge where cfg_valid=1
// while a frame is open (SHIFT, or IDLE/SHIFT together with cfg_start);
// cfg_valid=0 is a stall with no timeout. There is no ready back-pressure:
// the loader accepts a bit in every cycle it is offered one.
module clb_cfg_loader #(
  parameter int FRAME_DATA_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [16:0] ui_PAD2CORE,
  output logic [16:0] uo_CORE2PAD
);

`ifdef CLB_CFG_PARITY_EN
  localparam int FRAME_BITS = FRAME_DATA_BITS + 1;
`else
  localparam int FRAME_BITS = FRAME_DATA_BITS;
`endif
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // Pad inputs
  logic w_a;
  logic w_b;
  logic w_valid;
  logic w_bit;
  logic w_start;

  assign w_a     = ui_PAD2CORE[0];
  assign w_b     = ui_PAD2CORE[1];
  assign w_valid = ui_PAD2CORE[2];
  assign w_bit   = ui_PAD2CORE[3];
  assign w_start = ui_PAD2CORE[4];

  // Loader state
  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [FRAME_BITS-1:0]   r_sr;
  logic                    r_done;
  logic                    r_err;

  // Active configuration
  logic [3:0]              r_lut;
  logic                    r_use_ff;
  logic                    r_ff_init;
  logic                    r_ff_q;

  logic w_lut_out;
  logic w_last_bit;
  logic w_frame_ok;
  logic w_commit;
  logic w_busy;
  logic w_y;
  logic w_unused;

  // LUT index is {A,B}: A selects the upper half of the truth table.
  assign w_lut_out  = r_lut[{w_a, w_b}];
  assign w_last_bit = (r_cnt == CNT_W'(FRAME_BITS - 1));

`ifdef CLB_CFG_PARITY_EN
  // Even parity across data and parity bit: an odd total marks a corrupt frame.
  assign w_frame_ok = ~(^r_sr);
`else
  assign w_frame_ok = 1'b1;
`endif

  assign w_commit = (r_state == S_CHECK) && w_frame_ok;
  assign w_busy   = (r_state != S_IDLE);
  assign w_y      = r_use_ff ? r_ff_q : w_lut_out;

  // Upper pad bits carry nothing; the stored ff_init is only observable via ff_q.
  assign w_unused = ^{ui_PAD2CORE[16:5], r_ff_init};

  // Frame FSM: start/restart, serial shift, one-cycle check with done/err flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_SHIFT: begin
          if (w_start) begin
            // Open (or reopen) a frame; a coincident valid bit becomes bit 0.
            r_state <= S_SHIFT;
            r_err   <= 1'b0;
            if (w_valid) begin
              r_cnt <= CNT_W'(1);
              r_sr  <= {w_bit, {(FRAME_BITS-1){1'b0}}};
            end else begin
              r_cnt <= '0;
              r_sr  <= '0;
            end
          end else if ((r_state == S_SHIFT) && w_valid) begin
            // LSB first: new bit enters at the top, frame bit 0 ends in r_sr[0].
            r_sr  <= {w_bit, r_sr[FRAME_BITS-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_state <= S_CHECK;
              r_done  <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          // cfg_start is ignored here; the frame buffer is cleared on the way out.
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sr    <= '0;
          if (!w_frame_ok) r_err <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Active config commit and output flop; the flop takes ff_init on commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lut     <= 4'b1000;
      r_use_ff  <= 1'b0;
      r_ff_init <= 1'b0;
      r_ff_q    <= 1'b0;
    end else if (w_commit) begin
      r_lut     <= r_sr[3:0];
      r_use_ff  <= r_sr[4];
      r_ff_init <= r_sr[5];
      r_ff_q    <= r_sr[5];
    end else begin
      r_ff_q    <= w_lut_out;
    end
  end

  assign uo_CORE2PAD = {7'b0, r_ff_q, r_use_ff, r_lut, r_err, r_done, w_busy, w_y};

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: reset values, commits, parity error
// handling (when CLB_CFG_PARITY_EN is defined), registered mode latency,
// stalls, restart and reset mid-frame.
module tb_clb_cfg_loader;

`ifdef CLB_CFG_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a, b, v, bt, st;
  logic [11:0] junk;
  logic [16:0] ui;
  logic [16:0] uo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ui = {junk, st, bt, v, b, a};

  clb_cfg_loader #(.FRAME_DATA_BITS(6)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ui_PAD2CORE (ui),
    .uo_CORE2PAD (uo)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] mk_frame(input logic [3:0] lut, input logic uf,
                                          input logic fi, input logic good);
    logic par;
    par = (^{fi, uf, lut}) ^ ~good;
    return {par, fi, uf, lut};
  endfunction

  // Start edge with no bit, then NB back-to-back bits; returns in the CHECK cycle.
  task automatic send_frame(input logic [6:0] f);
    st = 1'b1; v = 1'b0;
    step();
    st = 1'b0;
    for (int i = 0; i < NB; i++) begin
      v = 1'b1; bt = f[i];
      step();
    end
    v = 1'b0; bt = 1'b0;
  endtask

  logic [6:0] f1, f2;

  initial begin
    // Reset with arbitrary control inputs; {A,B}=01 indexes a 0 entry of AND.
    rst_n = 1'b0;
    a = 1'b0; b = 1'b1;
    v  = 1'($urandom_range(0, 1));
    bt = 1'($urandom_range(0, 1));
    st = 1'($urandom_range(0, 1));
    junk = 12'($urandom_range(0, 4095));
    repeat (2) @(posedge clk);
    #2;
    check("rst_lut",    uo[7:4], 8'h8);
    check("rst_use_ff", uo[8],   0);
    check("rst_ff_q",   uo[9],   0);
    check("rst_y",      uo[0],   0);
    check("rst_busy",   uo[1],   0);
    check("rst_done",   uo[2],   0);
    check("rst_err",    uo[3],   0);
    check("rst_hi",     8'(uo[16:10]), 0);

    @(negedge clk);
    rst_n = 1'b1; st = 1'b0; v = 1'b0;
    a = 1'b1; b = 1'b1;
    #1 check("and_11", uo[0], 1);
    step();
    a = 1'b1; b = 1'b0;
    #1 check("and_10", uo[0], 0);

    // XOR commit; start during CHECK must be ignored.
    send_frame(mk_frame(4'b0110, 1'b0, 1'b0, 1'b1));
    a = 1'b1; b = 1'b1; st = 1'b1;
    #1;
    check("xor_chk_done", uo[2],   1);
    check("xor_chk_busy", uo[1],   1);
    check("xor_chk_lut",  uo[7:4], 8'h8);
    check("xor_chk_y_old", uo[0],  1);
    step();
    st = 1'b0; a = 1'b1; b = 1'b0;
    #1;
    check("xor_done_off", uo[2],   0);
    check("xor_busy_idle", uo[1],  0);
    check("xor_lut",      uo[7:4], 8'h6);
    check("xor_use_ff",   uo[8],   0);
    check("xor_err",      uo[3],   0);
    check("xor_y_10",     uo[0],   1);
    a = 1'b1; b = 1'b1;
    #1 check("xor_y_11", uo[0], 0);

`ifdef CLB_CFG_PARITY_EN
    // Bad parity: lut=1110 with parity bit 1 gives an odd total.
    send_frame(mk_frame(4'b1110, 1'b0, 1'b1, 1'b0));
    #1 check("bad_done", uo[2], 1);
    step();
    #1;
    check("bad_done_off", uo[2],   0);
    check("bad_err",      uo[3],   1);
    check("bad_lut",      uo[7:4], 8'h6);
    check("bad_use_ff",   uo[8],   0);
    step(); step();
    #1;
    check("bad_err_sticky", uo[3], 1);
    check("bad_busy",       uo[1], 0);
`else
    step(); step();
    #1 check("nopar_err", uo[3], 0);
`endif

    // Registered mode: lut=1110, use_ff=1, ff_init=1.
    send_frame(mk_frame(4'b1110, 1'b1, 1'b1, 1'b1));
    a = 1'b0; b = 1'b0;
    #1;
    check("reg_chk_done",  uo[2], 1);
    check("reg_chk_err",   uo[3], 0);
    check("reg_chk_uf",    uo[8], 0);
    check("reg_chk_y_old", uo[0], 0);
    step();
    #1;
    check("reg_use_ff", uo[8],   1);
    check("reg_lut",    uo[7:4], 8'hE);
    check("reg_ff_q",   uo[9],   1);
    check("reg_y_init", uo[0],   1);
    step();
    #1;
    check("reg_y_00",   uo[0], 0);
    check("reg_ffq_00", uo[9], 0);
    a = 1'b1; b = 1'b1;
    #1 check("reg_y_latency", uo[0], 0);
    step();
    #1 check("reg_y_11", uo[0], 1);

    // Stalls and restart: 3 bits of a dummy frame, then restart with XNOR.
    f1 = 7'b1111111;
    f2 = mk_frame(4'b1001, 1'b0, 1'b0, 1'b1);
    st = 1'b1; v = 1'b0;
    step();
    st = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = 1'b1; bt = f1[i];
      step();
      v = 1'b0;
      step();
    end
    #1 check("stall_busy", uo[1], 1);
    st = 1'b1; v = 1'b1; bt = f2[0];
    step();
    st = 1'b0;
    for (int i = 1; i < NB; i++) begin
      v = 1'b0;
      step();
      step();
      v = 1'b1; bt = f2[i];
      if (i == NB - 1) begin
        #1;
        check("rst_frame_no_early_done", uo[2], 0);
        check("rst_frame_busy",          uo[1], 1);
      end
      step();
    end
    v = 1'b0;
    #1;
    check("restart_done", uo[2],   1);
    check("restart_old",  uo[7:4], 8'hE);
    step();
    a = 1'b0; b = 1'b0;
    #1;
    check("restart_lut",    uo[7:4], 8'h9);
    check("restart_use_ff", uo[8],   0);
    check("restart_y_00",   uo[0],   1);
    a = 1'b0; b = 1'b1;
    #1 check("restart_y_01", uo[0], 0);

    // Reset mid-frame.
    st = 1'b1; v = 1'b0;
    step();
    st = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = 1'b1; bt = 1'b1;
      step();
    end
    v = 1'b0;
    #1 check("mid_busy", uo[1], 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", uo[1],   0);
    check("mid_rst_lut",  uo[7:4], 8'h8);
    check("mid_rst_uf",   uo[8],   0);
    check("mid_rst_ffq",  uo[9],   0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NB + 1; i++) begin
      v = 1'b1; bt = 1'b1;
      step();
    end
    v = 1'b0;
    #1;
    check("post_rst_busy", uo[1],   0);
    check("post_rst_done", uo[2],   0);
    check("post_rst_lut",  uo[7:4], 8'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
